sar_conv_ctrl: RTL and testbench
================================

Name: sar_conv_ctrl

Overview:
Conversion sequencer and result buffer that sits directly around the SAR logic stage. It issues periodic single-cycle cnvst pulses and waits for the eoc pulse. On eoc it captures the 8-bit sar word into a small FIFO. The FIFO drains over a valid/ready interface to the digital back end, with sticky overflow and timeout error flags.

Parameters:
PERIOD_W, 16, width of the programmable conversion period.
FIFO_DEPTH, 4, result FIFO entries; power of 2, minimum 2.
TIMEOUT, 64, maximum cycles in BUSY before the conversion is abandoned.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset, asynchronous assert, active-low (0 = reset).
enable  input  1  1 = run periodic conversions.
period  input  PERIOD_W  cycles between successive cnvst pulses; sampled at each cnvst.
cnvst  output  1  start-conversion pulse to SAR logic, one cycle wide.
eoc  input  1  end-of-conversion pulse from SAR logic.
sar_in  input  8  SAR result; valid in the cycle eoc=1.
dout  output  8  FIFO head data.
dout_valid  output  1  FIFO not empty.
dout_ready  input  1  consumer accepts dout this cycle.
fifo_level  output  $clog2(FIFO_DEPTH)+1  current entry count.
busy  output  1  1 while state is TRIG or BUSY.
overflow  output  1  sticky: a result was dropped.
timeout_err  output  1  sticky: eoc not seen within TIMEOUT cycles.
clr_err  input  1  clears overflow and timeout_err.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnvst=0, counters=0, FIFO empty, dout=0, dout_valid=0, fifo_level=0, overflow=0, timeout_err=0.
- All outputs are registered except dout_valid, which is (level!=0), and dout, which is the head entry.
- State machine has three states: IDLE, TRIG, BUSY.
- IDLE: period_cnt increments, saturating at all-ones.
  - Go to TRIG when enable=1 and period_cnt >= period_lat-1.
  - period_lat is 0 after reset, so the first trigger comes one cycle after enable.
- TRIG: cnvst=1 for exactly this cycle. period_lat<=period, period_cnt<=0, to_cnt<=0. Go to BUSY.
- BUSY: period_cnt and to_cnt both increment.
  - eoc=1: capture sar_in into the FIFO, go to IDLE.
  - to_cnt==TIMEOUT-1 without eoc: timeout_err<=1, go to IDLE, nothing written.
- Period semantics:
  - With period >= conversion length, cnvst rising edges are exactly period cycles apart.
  - If the conversion is longer than period, the next cnvst comes 1 cycle after the BUSY->IDLE transition.
  - period=0 is treated as period=1.
- enable=0 during TRIG/BUSY: the conversion completes and its result is captured; no new trigger until enable=1.
- eoc outside BUSY: ignored, with no write and no flag.
- FIFO write/read:
  - Write on eoc in BUSY. Pop on dout_valid && dout_ready.
  - Full with no pop: drop the new result, overflow<=1.
  - Full with simultaneous pop: write accepted, level unchanged.
  - Empty with write: dout_valid rises the next cycle. No fall-through of sar_in to dout in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; level is 0..FIFO_DEPTH.
- clr_err=1 clears both sticky flags next edge; a set event in the same cycle wins (flag stays 1).
- Reset asserted mid-conversion: immediate return to IDLE, cnvst=0, FIFO contents discarded.

Test Plan:
1. enable=1, period=20, eoc returned 12 cycles after each cnvst with sar_in=0xA5,0x3C,0x7F, dout_ready=1 -> cnvst pulses 1 cycle wide, 20 cycles apart; dout sequence A5,3C,7F, each valid 1 cycle after its eoc.
2. period=5, eoc 12 cycles after cnvst -> each new cnvst occurs 2 cycles after the previous eoc; no overflow.
3. dout_ready=0, 6 conversions of 0x01..0x06, FIFO_DEPTH=4 -> fifo_level=4; overflow=1 after the 5th eoc. Then dout_ready=1 drains 01,02,03,04, dout_valid=0 after.
4. FIFO full, eoc in the same cycle as a pop -> new value accepted, level stays 4, overflow stays 0.
5. cnvst issued, eoc never returned -> timeout_err=1 exactly TIMEOUT cycles after cnvst; the next cnvst follows the period rule. Asserting clr_err then gives timeout_err=0.
6. rst=0 asserted asynchronously mid-BUSY with 2 entries queued -> all outputs go to reset values without a clock edge. After release with enable=1, cnvst appears 1 cycle later.

Source files
------------

// File: rtl/sar_conv_ctrl.sv
// SAR conversion sequencer: periodic cnvst pulses, eoc capture into a small
// result FIFO drained over valid/ready, with sticky overflow/timeout flags.
module sar_conv_ctrl #(
    parameter int PERIOD_W   = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [PERIOD_W-1:0]         period,
    output logic                        cnvst,
    input  logic                        eoc,
    input  logic [7:0]                  sar_in,
    output logic [7:0]                  dout,
    output logic                        dout_valid,
    input  logic                        dout_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        busy,
    output logic                        overflow,
    output logic                        timeout_err,
    input  logic                        clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] TRIG = 2'd1;
    localparam logic [1:0] BUSY = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [PERIOD_W-1:0] period_cnt;
    logic [PERIOD_W-1:0] period_lat;
    logic [TW-1:0]       to_cnt;
    logic [PERIOD_W:0]   cnt_plus1;
    logic [PERIOD_W:0]   lat_minus1;
    logic                period_done;
    logic                to_expired;

    logic [7:0]          mem [FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic                wr_req;
    logic                wr_en;
    logic                pop;
    logic                full;
    logic                set_ovf;
    logic                set_to;

    // Counters restart in TRIG, so the TRIG cycle itself is uncounted; both
    // thresholds sit one lower so period and timeout are measured from cnvst.
    always_comb begin
        cnt_plus1   = {1'b0, period_cnt} + (PERIOD_W+1)'(1);
        lat_minus1  = (period_lat == '0) ? '0 : {1'b0, period_lat} - (PERIOD_W+1)'(1);
        period_done = (cnt_plus1 >= lat_minus1);
        to_expired  = (to_cnt == TW'(TIMEOUT - 2));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable && period_done) state_nxt = TRIG;
            TRIG:    state_nxt = BUSY;
            BUSY:    if (eoc || to_expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnvst      <= 1'b0;
            busy       <= 1'b0;
            period_cnt <= '0;
            period_lat <= '0;
            to_cnt     <= '0;
        end else begin
            state <= state_nxt;
            cnvst <= (state_nxt == TRIG);
            busy  <= (state_nxt != IDLE);
            case (state)
                TRIG: begin
                    period_lat <= period;
                    period_cnt <= '0;
                    to_cnt     <= '0;
                end
                BUSY: begin
                    if (period_cnt != '1) period_cnt <= period_cnt + PERIOD_W'(1);
                    to_cnt <= to_cnt + TW'(1);
                end
                default: begin
                    if (period_cnt != '1) period_cnt <= period_cnt + PERIOD_W'(1);
                end
            endcase
        end
    end

    always_comb begin
        wr_req  = (state == BUSY) && eoc;
        full    = (fifo_level == LW'(FIFO_DEPTH));
        pop     = dout_valid && dout_ready;
        wr_en   = wr_req && (!full || pop);
        set_ovf = wr_req && full && !pop;
        set_to  = (state == BUSY) && !eoc && to_expired;
    end

    assign dout_valid = (fifo_level != '0);
    assign dout       = mem[rd_ptr];

    // When full, wr_ptr == rd_ptr, so a write with a pop refills the freed slot.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem        <= '{default: '0};
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= sar_in;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   fifo_level <= fifo_level + LW'(1);
                2'b01:   fifo_level <= fifo_level - LW'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (set_ovf)      overflow <= 1'b1;
            else if (clr_err) overflow <= 1'b0;
            if (set_to)       timeout_err <= 1'b1;
            else if (clr_err) timeout_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_conv_ctrl.sv
// Directed bench for sar_conv_ctrl: period timing, FIFO fill/drain, overflow,
// simultaneous pop/write, timeout, error clear and asynchronous reset.
module tb_sar_conv_ctrl;

    localparam int TO = 16;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] period;
    logic        cnvst;
    logic        eoc;
    logic [7:0]  sar_in;
    logic [7:0]  dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [2:0]  fifo_level;
    logic        busy;
    logic        overflow;
    logic        timeout_err;
    logic        clr_err;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    sar_conv_ctrl #(.PERIOD_W(16), .FIFO_DEPTH(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .enable(enable), .period(period), .cnvst(cnvst),
        .eoc(eoc), .sar_in(sar_in), .dout(dout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .fifo_level(fifo_level), .busy(busy),
        .overflow(overflow), .timeout_err(timeout_err), .clr_err(clr_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cnvst();
        for (int i = 0; i < 200; i++) begin
            if (cnvst === 1'b1) break;
            step();
        end
        chk("cnvst_seen", cnvst, 1);
    endtask

    // eoc lands lat cycles after the cnvst cycle; returns on the cycle after eoc
    task automatic convert(input logic [7:0] val, input int lat, input bit pop_at_eoc,
                           output int c_cyc);
        wait_cnvst();
        c_cyc = cyc;
        step();
        chk("cnvst_width", cnvst, 0);
        repeat (lat - 1) step();
        eoc = 1'b1;
        sar_in = val;
        if (pop_at_eoc) dout_ready = 1'b1;
        step();
        eoc = 1'b0;
        sar_in = '0;
        if (pop_at_eoc) dout_ready = 1'b0;
    endtask

    initial begin
        int c1, c2, c3, c4, c5, c6, c7, c8, cx;

        rst = 1'b0; enable = 1'b0; period = '0; eoc = 1'b0; sar_in = '0;
        dout_ready = 1'b0; clr_err = 1'b0;
        step(); step();
        chk("rst_cnvst", cnvst, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_to", timeout_err, 0);
        rst = 1'b1;
        step();
        chk("idle_no_cnvst", cnvst, 0);

        // period 20, eoc 12 cycles after cnvst
        period = 16'd20; enable = 1'b1; dout_ready = 1'b1;
        step();
        chk("first_cnvst", cnvst, 1);
        chk("first_busy", busy, 1);
        convert(8'hA5, 12, 1'b0, c1);
        chk("t1_valid0", dout_valid, 1);
        chk("t1_dout0", dout, 8'hA5);
        convert(8'h3C, 12, 1'b0, c2);
        chk("t1_space1", c2 - c1, 20);
        chk("t1_valid1", dout_valid, 1);
        chk("t1_dout1", dout, 8'h3C);
        convert(8'h7F, 12, 1'b0, c3);
        chk("t1_space2", c3 - c2, 20);
        chk("t1_dout2", dout, 8'h7F);
        chk("t1_ovf", overflow, 0);

        // period 5 shorter than conversion: cnvst 2 cycles after eoc
        period = 16'd5;
        convert(8'h40, 12, 1'b0, c4);
        chk("t2_latched", c4 - c3, 20);
        convert(8'h41, 12, 1'b0, c5);
        chk("t2_space1", c5 - c4, 14);
        convert(8'h42, 12, 1'b0, c6);
        chk("t2_space2", c6 - c5, 14);
        chk("t2_ovf", overflow, 0);

        // fill with no consumer, overflow on the 5th result
        step();
        dout_ready = 1'b0;
        chk("t3_empty", fifo_level, 0);
        for (int i = 1; i <= 6; i++) begin
            convert(8'(i), 3, 1'b0, cx);
            chk("t3_level", fifo_level, (i > 4) ? 4 : i);
            chk("t3_ovf", overflow, (i >= 5) ? 1 : 0);
        end
        enable = 1'b0;
        step();
        chk("t3_stopped", cnvst, 0);
        dout_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain_valid", dout_valid, 1);
            chk("t3_drain_dout", dout, i);
            step();
        end
        dout_ready = 1'b0;
        chk("t3_drained", dout_valid, 0);
        chk("t3_level0", fifo_level, 0);
        chk("t3_ovf_sticky", overflow, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t3_ovf_clr", overflow, 0);

        // full FIFO, eoc together with a pop
        enable = 1'b1;
        for (int i = 0; i < 4; i++) convert(8'h11 + 8'(i), 3, 1'b0, cx);
        chk("t4_full", fifo_level, 4);
        convert(8'h15, 3, 1'b1, cx);
        enable = 1'b0;
        chk("t4_level", fifo_level, 4);
        chk("t4_ovf", overflow, 0);
        chk("t4_head", dout, 8'h12);
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain", dout, 8'h12 + i);
            step();
        end
        chk("t4_empty", dout_valid, 0);

        // no eoc: timeout, then next cnvst by the period rule
        period = 16'd30; enable = 1'b1;
        wait_cnvst();
        c7 = cyc;
        repeat (TO - 1) step();
        chk("t5_busy_pre", busy, 1);
        chk("t5_to_pre", timeout_err, 0);
        step();
        chk("t5_to_set", timeout_err, 1);
        chk("t5_busy_post", busy, 0);
        chk("t5_no_write", fifo_level, 0);
        convert(8'h5A, 4, 1'b0, c8);
        enable = 1'b0;
        chk("t5_space", c8 - c7, 30);
        chk("t5_dout", dout, 8'h5A);
        step();
        chk("t5_popped", dout_valid, 0);
        eoc = 1'b1; sar_in = 8'hEE;
        step();
        eoc = 1'b0; sar_in = '0;
        step();
        chk("stray_eoc_level", fifo_level, 0);
        chk("stray_eoc_ovf", overflow, 0);
        chk("t5_to_sticky", timeout_err, 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("t5_to_clr", timeout_err, 0);

        // asynchronous reset mid-BUSY with two entries queued
        period = 16'd5; enable = 1'b1; dout_ready = 1'b0;
        convert(8'h21, 3, 1'b0, cx);
        convert(8'h22, 3, 1'b0, cx);
        chk("t6_level2", fifo_level, 2);
        wait_cnvst();
        step(); step();
        chk("t6_busy", busy, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_cnvst", cnvst, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_valid", dout_valid, 0);
        chk("t6_dout", dout, 0);
        chk("t6_ovf", overflow, 0);
        chk("t6_to", timeout_err, 0);
        step();
        chk("t6_held", cnvst, 0);
        rst = 1'b1;
        step();
        chk("t6_restart", cnvst, 1);
        chk("t6_restart_lvl", fifo_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
